// File: rtl/sr_ctrl_pkg.sv
// Shared encodings for the sr_ff command arbiter: FSM states and set/clear ops.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_e;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

   // Round-robin pointer values: which requester wins a tie.
   localparam logic RR_FAV_A = 1'b0;
   localparam logic RR_FAV_B = 1'b1;

endpackage

// File: rtl/sr_ff_arbiter_gap_counter.sv
// Loadable up/down counter whose terminal-count flag times the post-command idle gap.
// Latency: count updates one cycle after en_i/load_i; tc_o is decoded from the register.
// Backpressure: none; the counter moves only when the owner enables it.
module gap_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         en_i,
   input  logic         up_i,
   input  logic [W-1:0] load_val_i,
   input  logic [W-1:0] tc_val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load has priority over counting.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = up_i ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
   end

   // Count register, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/sr_ff_arbiter.sv
// Round-robin arbiter sharing one sr_ff between two set/clear requesters, with a shadow Q.
// Latency: req sampled in IDLE at edge t -> gnt and S/R high for cycle t..t+1, q_shadow valid after t+1.
// Backpressure: requests are level-held; they are ignored (not queued) while busy in ISSUE/GAP.
module sr_ff_arbiter
   import sr_ctrl_pkg::*;
#(
   parameter int GAP_CYCLES = 2,
   parameter int CNT_W      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic op_a,
   input  logic req_b,
   input  logic op_b,
   output logic gnt_a,
   output logic gnt_b,
   output logic S,
   output logic R,
   output logic q_shadow,
   output logic busy
);

   // A zero gap skips the GAP state entirely, so the terminal value is then don't-care.
   localparam logic             HAS_GAP = (GAP_CYCLES > 0);
   localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_e state_q, state_d;
   logic   ptr_q,   ptr_d;
   logic   op_q,    op_d;
   logic   gnt_a_q, gnt_a_d;
   logic   gnt_b_q, gnt_b_d;
   logic   s_q,     s_d;
   logic   r_q,     r_d;
   logic   q_q,     q_d;
   logic   busy_q,  busy_d;
   logic   pick_b;
   logic   gap_load;
   logic   gap_en;
   logic   gap_tc;

   gap_counter #(
      .W (CNT_W)
   ) u_gap (
      .clk        (clk),
      .rst        (rst),
      .load_i     (gap_load),
      .en_i       (gap_en),
      .up_i       (1'b1),
      .load_val_i ('0),
      .tc_val_i   (GAP_TC),
      .tc_o       (gap_tc)
   );

   // Next state and next registered outputs; S/R/gnt are computed on the winning edge
   // so that they are register outputs during the ISSUE cycle.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      op_d     = op_q;
      gnt_a_d  = 1'b0;
      gnt_b_d  = 1'b0;
      s_d      = 1'b0;
      r_d      = 1'b0;
      q_d      = q_q;
      gap_load = 1'b0;
      gap_en   = 1'b0;
      pick_b   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_a || req_b) begin
               pick_b  = req_b && (!req_a || (ptr_q == RR_FAV_B));
               op_d    = pick_b ? op_b : op_a;
               ptr_d   = pick_b ? RR_FAV_A : RR_FAV_B;
               gnt_a_d = !pick_b;
               gnt_b_d = pick_b;
               s_d     = (op_d == OP_SET) && !q_q;
               r_d     = (op_d == OP_CLR) && q_q;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // The flop captures the pulse on this edge, so the shadow follows here.
            q_d = (op_q == OP_SET);
            if (((op_q == OP_SET) == q_q) || !HAS_GAP) begin
               state_d = IDLE;
            end else begin
               gap_load = 1'b1;
               state_d  = GAP;
            end
         end
         GAP: begin
            gap_en = 1'b1;
            if (gap_tc) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, pointer and output registers; reset abandons any command in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= RR_FAV_A;
         op_q    <= OP_CLR;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         q_q     <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         op_q    <= op_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         s_q     <= s_d;
         r_q     <= r_d;
         q_q     <= q_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt_a    = gnt_a_q;
   assign gnt_b    = gnt_b_q;
   assign S        = s_q;
   assign R        = r_q;
   assign q_shadow = q_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_sr_ff_arbiter.sv
// Directed bench for sr_ff_arbiter: GAP_CYCLES=2 instance plus a GAP_CYCLES=0 instance.
// Latency: expected output vectors are queued per cycle and compared at the following negedge.
// Backpressure: n/a; requesters are driven directly.
module tb_sr_ff_arbiter;

   logic clk;
   logic rst;
   logic req_a, op_a, req_b, op_b;

   logic gnt_a_m, gnt_b_m, s_m, r_m, q_m, busy_m;
   logic gnt_a_z, gnt_b_z, s_z, r_z, q_z, busy_z;

   // Observed vectors: {gnt_a, gnt_b, S, R, q_shadow, busy}
   logic [5:0] obs_main, obs_g0;
   assign obs_main = {gnt_a_m, gnt_b_m, s_m, r_m, q_m, busy_m};
   assign obs_g0   = {gnt_a_z, gnt_b_z, s_z, r_z, q_z, busy_z};

   int n_checks = 0;
   int n_pass   = 0;
   logic dut_sel = 1'b0;   // 0: check GAP=2 instance, 1: check GAP=0 instance

   typedef struct {
      string      tag;
      logic [5:0] vec;
   } exp_t;
   exp_t sb[$];

   sr_ff_arbiter #(.GAP_CYCLES(2), .CNT_W(4)) dut_main (
      .clk(clk), .rst(rst),
      .req_a(req_a), .op_a(op_a), .req_b(req_b), .op_b(op_b),
      .gnt_a(gnt_a_m), .gnt_b(gnt_b_m), .S(s_m), .R(r_m),
      .q_shadow(q_m), .busy(busy_m)
   );

   sr_ff_arbiter #(.GAP_CYCLES(0), .CNT_W(4)) dut_g0 (
      .clk(clk), .rst(rst),
      .req_a(req_a), .op_a(op_a), .req_b(req_b), .op_b(op_b),
      .gnt_a(gnt_a_z), .gnt_b(gnt_b_z), .S(s_z), .R(r_z),
      .q_shadow(q_z), .busy(busy_z)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic push(input string tag, input logic [5:0] v);
      exp_t e;
      e.tag = tag;
      e.vec = v;
      sb.push_back(e);
   endtask

   task automatic check_now(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Advance one clock and compare the oldest queued expectation.
   task automatic step();
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
         check_now("scoreboard_empty", 6'b111111, 6'b000000);
      end else begin
         e = sb.pop_front();
         check_now(e.tag, dut_sel ? obs_g0 : obs_main, e.vec);
      end
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      push("in_reset", 6'b000000);
      step();
      rst = 1'b0;
   endtask

   // Safety invariants on both instances every cycle.
   always @(negedge clk) begin
      n_checks++;
      assert (!(s_m && r_m) && !(gnt_a_m && gnt_b_m) && !(s_z && r_z) && !(gnt_a_z && gnt_b_z))
         n_pass++;
      else $error("FAIL invariant: main SR=%b%b GG=%b%b g0 SR=%b%b GG=%b%b required no pair high",
                  s_m, r_m, gnt_a_m, gnt_b_m, s_z, r_z, gnt_a_z, gnt_b_z);
   end

   initial begin
      rst   = 1'b0;
      req_a = 1'b0; op_a = 1'b0;
      req_b = 1'b0; op_b = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      check_now("rst_main", obs_main, 6'b000000);
      check_now("rst_g0",   obs_g0,   6'b000000);
      rst = 1'b0;

      // Single set from A with a 2-cycle gap.
      req_a = 1'b1; op_a = 1'b1;
      push("t1_issue", 6'b101001); step();
      req_a = 1'b0;
      push("t1_gap0", 6'b000011); step();
      push("t1_gap1", 6'b000011); step();
      push("t1_idle", 6'b000010); step();

      // Simultaneous: A redundant clear first, then B set.
      reset_pulse();
      req_a = 1'b1; op_a = 1'b0; req_b = 1'b1; op_b = 1'b1;
      push("t2_a_redundant", 6'b100001); step();
      req_a = 1'b0;
      push("t2_nogap_idle", 6'b000000); step();
      push("t2_b_issue",    6'b011001); step();
      req_b = 1'b0;
      push("t2_gap0", 6'b000011); step();
      push("t2_gap1", 6'b000011); step();
      push("t2_idle", 6'b000010); step();

      // Both held: grants alternate A (set), B (clear), spaced 4 cycles.
      reset_pulse();
      req_a = 1'b1; op_a = 1'b1; req_b = 1'b1; op_b = 1'b0;
      for (int k = 0; k < 2; k++) begin
         push("t3_a_issue", 6'b101001); step();
         push("t3_a_gap0",  6'b000011); step();
         push("t3_a_gap1",  6'b000011); step();
         push("t3_a_idle",  6'b000010); step();
         push("t3_b_issue", 6'b010111); step();
         push("t3_b_gap0",  6'b000001); step();
         push("t3_b_gap1",  6'b000001); step();
         push("t3_b_idle",  6'b000000); step();
      end
      req_a = 1'b0; req_b = 1'b0;

      // Request arriving during GAP waits for the return to IDLE.
      req_a = 1'b1; op_a = 1'b1;
      push("t4_a_issue", 6'b101001); step();
      req_a = 1'b0;
      push("t4_gap0", 6'b000011); step();
      req_b = 1'b1; op_b = 1'b0;
      push("t4_gap1_nogrant", 6'b000011); step();
      push("t4_idle_nogrant", 6'b000010); step();
      push("t4_b_issue",      6'b010111); step();
      req_b = 1'b0;
      push("t4_b_gap0", 6'b000001); step();
      push("t4_b_gap1", 6'b000001); step();
      push("t4_b_idle", 6'b000000); step();

      // Async reset mid-ISSUE; pending pair re-arbitrated with A favoured.
      req_a = 1'b1; op_a = 1'b1; req_b = 1'b1; op_b = 1'b1;
      push("t5_issue", 6'b101001); step();
      #2 rst = 1'b1;
      #1 check_now("t5_async_drop", obs_main, 6'b000000);
      push("t5_in_reset", 6'b000000); step();
      rst = 1'b0;
      push("t5_rearb_a", 6'b101001); step();
      req_a = 1'b0; req_b = 1'b0;
      push("t5_gap0", 6'b000011); step();
      push("t5_gap1", 6'b000011); step();
      push("t5_idle", 6'b000010); step();

      // GAP_CYCLES=0 instance: back-to-back set then clear from A.
      dut_sel = 1'b1;
      reset_pulse();
      req_a = 1'b1; op_a = 1'b1;
      push("t6_set_issue", 6'b101001); step();
      op_a = 1'b0;
      push("t6_idle",      6'b000010); step();
      push("t6_clr_issue", 6'b100111); step();
      req_a = 1'b0;
      push("t6_idle_end",  6'b000000); step();
      push("t6_quiet",     6'b000000); step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
